multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: FETCH / EXECUTE / LOAD / HALT sequencer with an ARMv8-subset decoder.
// Optional MCU_COND_BRANCH_EN adds B.cond; the full field set is 30 bits, so the default CW_W=29 drops the always-zero EN_PC MSB.
module multicycle_control_unit #(
  parameter int CW_W = 29
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [4:0]      status,
  output logic [CW_W-1:0] control_word,
  output logic [63:0]     constant,
  output logic            halted
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    LOAD    = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_ORR  = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_SUB  = 5'b01001;
  localparam logic [4:0] FS_PASS = 5'b00100;

  state_t      state_r;
  logic [31:0] ir_r;
  logic        halted_r;

  logic        op_add_s, op_sub_s, op_and_s, op_orr_s;
  logic        op_addi_s, op_subi_s, op_stur_s, op_ldur_s;
  logic        op_b_s, op_cbz_s, op_alu_r_s, op_alu_i_s;

  logic [4:0]  rd_s, rn_s, rm_s;
  logic [63:0] imm_alu_s, off_dt_s, off_b_s, off_cb_s;

  logic        en_pc_s, en_mem_s, en_alu_s, pcsel_s, bsel_s, sl_s, wm_s, wr_s;
  logic [1:0]  ps_s;
  logic [4:0]  fs_s, sb_s, sa_s, da_s;
  logic [63:0] k_s;
  logic [29:0] cw_full_s;

  assign op_add_s   = (ir_r[31:21] == 11'b10001011000);
  assign op_sub_s   = (ir_r[31:21] == 11'b11001011000);
  assign op_and_s   = (ir_r[31:21] == 11'b10001010000);
  assign op_orr_s   = (ir_r[31:21] == 11'b10101010000);
  assign op_addi_s  = (ir_r[31:22] == 10'b1001000100);
  assign op_subi_s  = (ir_r[31:22] == 10'b1101000100);
  assign op_stur_s  = (ir_r[31:21] == 11'b11111000000);
  assign op_ldur_s  = (ir_r[31:21] == 11'b11111000010);
  assign op_b_s     = (ir_r[31:26] == 6'b000101);
  assign op_cbz_s   = (ir_r[31:24] == 8'b10110100);
  assign op_alu_r_s = op_add_s | op_sub_s | op_and_s | op_orr_s;
  assign op_alu_i_s = op_addi_s | op_subi_s;

  assign rd_s      = ir_r[4:0];
  assign rn_s      = ir_r[9:5];
  assign rm_s      = ir_r[20:16];
  assign imm_alu_s = {52'd0, ir_r[21:10]};
  assign off_dt_s  = {{55{ir_r[20]}}, ir_r[20:12]};
  assign off_b_s   = {{36{ir_r[25]}}, ir_r[25:0], 2'b00};
  assign off_cb_s  = {{43{ir_r[23]}}, ir_r[23:5], 2'b00};

`ifdef MCU_COND_BRANCH_EN
  logic op_bcond_s;
  logic unused_carry_s;
  assign op_bcond_s     = (ir_r[31:24] == 8'b01010100);
  assign unused_carry_s = status[3];

  // Evaluates an ARM condition code against the registered V, N, Z flags.
  function automatic logic cond_taken(input logic [3:0] cond, input logic v, input logic n,
                                      input logic z);
    logic taken;
    case (cond)
      4'b0000: taken = z;
      4'b0001: taken = ~z;
      4'b1010: taken = (n == v);
      4'b1011: taken = (n != v);
      4'b1100: taken = ~z & (n == v);
      4'b1101: taken = z | (n != v);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction
`else
  logic unused_flags_s;
  assign unused_flags_s = ^status[4:1];
`endif

  // State sequencing, instruction register capture and the halted flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= FETCH;
      ir_r     <= 32'd0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          ir_r     <= instruction;
          state_r  <= EXECUTE;
          halted_r <= 1'b0;
        end
        EXECUTE: begin
          if (ir_r == 32'd0) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
          end else if (op_ldur_s) begin
            state_r <= LOAD;
          end else begin
            state_r <= FETCH;
          end
        end
        LOAD: begin
          state_r <= FETCH;
        end
        HALT: begin
          state_r  <= HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= FETCH;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  // Control word and constant decode from state and IR; CBZ/B.cond also look at live status.
  always_comb begin
    en_pc_s  = 1'b0;
    en_mem_s = 1'b0;
    en_alu_s = 1'b0;
    pcsel_s  = 1'b0;
    bsel_s   = 1'b0;
    sl_s     = 1'b0;
    wm_s     = 1'b0;
    wr_s     = 1'b0;
    ps_s     = 2'b00;
    fs_s     = 5'd0;
    sb_s     = 5'd0;
    sa_s     = 5'd0;
    da_s     = 5'd0;
    k_s      = 64'd0;
    case (state_r)
      EXECUTE: begin
        if (ir_r == 32'd0) begin
          ps_s = 2'b00;
        end else if (op_alu_r_s || op_alu_i_s) begin
          en_alu_s = 1'b1;
          wr_s     = 1'b1;
          ps_s     = 2'b01;
          da_s     = rd_s;
          sa_s     = rn_s;
          sb_s     = rm_s;
          if (op_alu_i_s) begin
            bsel_s = 1'b1;
            k_s    = imm_alu_s;
            fs_s   = op_subi_s ? FS_SUB : FS_ADD;
          end else if (op_sub_s) begin
            fs_s = FS_SUB;
          end else if (op_and_s) begin
            fs_s = FS_AND;
          end else if (op_orr_s) begin
            fs_s = FS_ORR;
          end else begin
            fs_s = FS_ADD;
          end
        end else if (op_stur_s) begin
          fs_s   = FS_ADD;
          bsel_s = 1'b1;
          k_s    = off_dt_s;
          sa_s   = rn_s;
          sb_s   = rd_s;
          wm_s   = 1'b1;
          ps_s   = 2'b01;
        end else if (op_ldur_s) begin
          // Address phase only: the PC holds until LOAD retires the instruction.
          fs_s   = FS_ADD;
          bsel_s = 1'b1;
          sa_s   = rn_s;
          k_s    = off_dt_s;
        end else if (op_b_s) begin
          pcsel_s = 1'b1;
          k_s     = off_b_s;
          ps_s    = 2'b11;
        end else if (op_cbz_s) begin
          sb_s = rd_s;
          sa_s = 5'd31;
          fs_s = FS_PASS;
          k_s  = off_cb_s;
          if (status[0]) begin
            pcsel_s = 1'b1;
            ps_s    = 2'b11;
          end else begin
            ps_s = 2'b01;
          end
`ifdef MCU_COND_BRANCH_EN
        end else if (op_bcond_s) begin
          k_s = off_cb_s;
          if (cond_taken(ir_r[3:0], status[4], status[2], status[1])) begin
            pcsel_s = 1'b1;
            ps_s    = 2'b11;
          end else begin
            ps_s = 2'b01;
          end
`endif
        end else begin
          ps_s = 2'b01;
        end
      end
      LOAD: begin
        fs_s     = FS_ADD;
        bsel_s   = 1'b1;
        sa_s     = rn_s;
        k_s      = off_dt_s;
        en_mem_s = 1'b1;
        wr_s     = 1'b1;
        da_s     = rd_s;
        ps_s     = 2'b01;
      end
      default: begin
        ps_s = 2'b00;
      end
    endcase
  end

  assign cw_full_s = {en_pc_s, en_mem_s, en_alu_s, pcsel_s, bsel_s, sl_s, wm_s, wr_s,
                      ps_s, fs_s, sb_s, sa_s, da_s};

  assign control_word = CW_W'(cw_full_s);
  assign constant     = k_s;
  assign halted       = halted_r;

endmodule
